data_sram_responder: RTL and testbench

//   Memory-side responder for the CPU data SRAM port (we/addr/wdata/rdata).

---
 rtl/data_sram_responder.sv | 107 ++++++++++
 tb/tb_data_sram_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data SRAM port responder: on-chip RAM plus confreg window
// Reads are registered (1-cycle latency, read-before-write); confregs hold LED, NUM, TIMER.
module data_sram_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
  parameter logic [31:0] SIMU_FLAG = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_SW    = 16'hf010;
  localparam logic [15:0] OFF_NUM   = 16'hf020;
  localparam logic [15:0] OFF_TIMER = 16'he000;
  localparam logic [15:0] OFF_SIMU  = 16'hfff0;

  logic              conf_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       conf_off;
  logic              ram_we;
  logic              conf_we;

  logic [31:0] mem_q [RAM_DEPTH];

  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] conf_rdata;

  // Upper address bits outside the confreg window are ignored, so RAM aliases.
  assign conf_hit = (data_sram_addr & 32'hffff_0000) == CONF_BASE;
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign conf_off = data_sram_addr[15:0];
  assign ram_we   = data_sram_we & ~conf_hit;
  assign conf_we  = data_sram_we & conf_hit;

  // RAM contents survive reset; only the write is suppressed while reset is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
    end else if (ram_we) begin
      mem_q[ram_idx] <= data_sram_wdata;
    end
  end

  always_comb begin
    conf_rdata = 32'h0;
    case (conf_off)
      OFF_LED:   conf_rdata = {16'h0, led_q};
      OFF_SW:    conf_rdata = {24'h0, sw_sync_q};
      OFF_NUM:   conf_rdata = num_q;
      OFF_TIMER: conf_rdata = timer_q;
      OFF_SIMU:  conf_rdata = SIMU_FLAG;
      default:   conf_rdata = 32'h0;
    endcase
  end

  always_comb begin
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (conf_we) begin
      case (conf_off)
        OFF_LED:   led_d   = data_sram_wdata[15:0];
        OFF_NUM:   num_d   = data_sram_wdata;
        OFF_TIMER: timer_d = data_sram_wdata;
        default:   ;
      endcase
    end
  end

  assign rdata_d = conf_hit ? conf_rdata : mem_q[ram_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= 16'h0;
      num_q     <= 32'h0;
      timer_q   <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
      rdata_q   <= 32'h0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized model-checked bench for data_sram_responder
module tb_data_sram_responder;

  localparam logic [31:0] SIMU = 32'hffff_ffff;
  localparam logic [31:0] CB   = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;

  always #5 clk = ~clk;

  data_sram_responder #(
    .RAM_AW   (12),
    .CONF_BASE(CB),
    .SIMU_FLAG(SIMU)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch_in      (switch_in),
    .led            (led),
    .num_data       (num_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, as seen just after the most recent edge.
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] t_base;
  int          t_edge;
  int          edge_n;
  logic [7:0]  swq [$];
  logic        pend_v;
  logic [31:0] pend_exp;
  string       pend_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led  = 16'h0;
    m_num  = 32'h0;
    t_base = 32'h0;
    t_edge = edge_n;
    swq.delete();
    swq.push_back(8'h0);
    swq.push_back(8'h0);
    pend_v   = 1'b1;
    pend_exp = 32'h0;
    pend_tag = "rst_rdata";
  endtask

  // Called just after a negedge: checks the previous edge, predicts the next one, drives it.
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] sw);
    logic        conf;
    int          idx;
    logic [31:0] exp;
    logic        ev;
    string       tag;
    if (pend_v) check(pend_tag, data_sram_rdata, pend_exp);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num", num_data, m_num);
    conf = (addr & 32'hffff_0000) == CB;
    idx  = int'(addr[13:2]);
    swq.push_back(sw);
    ev  = 1'b1;
    exp = 32'h0;
    tag = "ram_rd";
    if (conf) begin
      tag = "conf_rd";
      case (addr[15:0])
        16'hf000: exp = {16'h0, m_led};
        16'hf010: begin exp = {24'h0, swq[0]}; tag = "sw_rd"; end
        16'hf020: exp = m_num;
        16'he000: begin exp = t_base + 32'(edge_n - t_edge); tag = "timer_rd"; end
        16'hfff0: exp = SIMU;
        default:  exp = 32'h0;
      endcase
      if (we) begin
        case (addr[15:0])
          16'hf000: m_led = wdata[15:0];
          16'hf020: m_num = wdata;
          16'he000: begin t_base = wdata; t_edge = edge_n + 1; end
          default:  ;
        endcase
      end
    end else begin
      if (m_mem.exists(idx)) exp = m_mem[idx];
      else ev = 1'b0;
      if (we) m_mem[idx] = wdata;
    end
    void'(swq.pop_front());
    pend_v   = ev;
    pend_exp = exp;
    pend_tag = tag;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    switch_in       = sw;
    edge_n++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [15:0] offs [7];
    offs = '{16'hf000, 16'hf010, 16'hf020, 16'he000, 16'hfff0, 16'hf030, 16'h0000};
    if ($urandom_range(0, 9) < 5) begin
      a = $urandom & 32'hffff_c03f;
      if ((a & 32'hffff_0000) == CB) a[31] = 1'b0;
    end else begin
      offs[6] = 16'($urandom);
      a = CB | {16'h0, offs[$urandom_range(0, 6)]};
    end
    return a;
  endfunction

  logic [7:0] sw_cur;

  initial begin
    resetn = 1'b0;
    data_sram_we = 1'b0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in = 8'h0;
    edge_n = 0;
    sw_cur = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_rdata0", data_sram_rdata, 32'h0);
    check("rst_led0", {16'h0, led}, 32'h0);
    check("rst_num0", num_data, 32'h0);
    resetn = 1'b1;
    model_reset();

    // RAM write then read, read-before-write
    cycle(1'b1, 32'h1c00_0010, 32'hdead_beef, 8'h0);
    cycle(1'b0, 32'h1c00_0010, 32'h0, 8'h0);
    cycle(1'b1, 32'h0000_0010, 32'h1111_1111, 8'h0);
    cycle(1'b1, 32'h0000_0010, 32'h2222_2222, 8'h0);
    cycle(1'b0, 32'h0000_0010, 32'h0, 8'h0);
    // confregs
    cycle(1'b1, CB | 32'hf000, 32'h0001_a5a5, 8'h0);
    cycle(1'b0, CB | 32'hf000, 32'h0, 8'h0);
    cycle(1'b1, CB | 32'hf020, 32'h1234_5678, 8'h0);
    cycle(1'b0, CB | 32'hf030, 32'h0, 8'h0);
    cycle(1'b1, CB | 32'hfff0, 32'h0bad_0bad, 8'h0);
    cycle(1'b0, CB | 32'hfff0, 32'h0, 8'h0);
    // timer wrap
    cycle(1'b1, CB | 32'he000, 32'hffff_fffe, 8'h0);
    repeat (4) cycle(1'b0, CB | 32'he000, 32'h0, 8'h0);
    // switch synchroniser
    repeat (4) cycle(1'b0, CB | 32'hf010, 32'h0, 8'h5a);

    // asynchronous reset mid-stream
    cycle(1'b1, 32'h0000_0020, 32'hcafe_f00d, 8'h5a);
    cycle(1'b1, CB | 32'hf000, 32'h0000_ffff, 8'h5a);
    cycle(1'b1, CB | 32'hf020, 32'h5555_aaaa, 8'h5a);
    if (pend_v) check(pend_tag, data_sram_rdata, pend_exp);
    #2;
    resetn = 1'b0;
    data_sram_we = 1'b1;
    data_sram_addr = 32'h0000_0020;
    data_sram_wdata = 32'hbad0_bad0;
    #1;
    check("arst_rdata", data_sram_rdata, 32'h0);
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_num", num_data, 32'h0);
    @(negedge clk);
    check("arst_hold_rdata", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    data_sram_we = 1'b0;
    model_reset();
    cycle(1'b0, CB | 32'he000, 32'h0, 8'h0);
    cycle(1'b0, CB | 32'he000, 32'h0, 8'h0);
    cycle(1'b0, 32'h0000_0020, 32'h0, 8'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw_cur = 8'($urandom);
      cycle($urandom_range(0, 9) < 4, rand_addr(), $urandom, sw_cur);
    end
    cycle(1'b0, 32'h0, 32'h0, sw_cur);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
